// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer: FSM states,
// opcode constants and the instruction classes produced by the opcode decoder.
package mc_pkg;

    localparam int OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier: the single place where raw opcodes are compared.
// Anything that is not one of the supported RV32I classes maps to CLS_ILLEGAL.
module mc_opdecode
    import mc_pkg::*;
#(
    parameter int OPCODE_WIDTH = 7
) (
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output instr_class_t            o_class
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OPCODE_WIDTH'(OP_R):      o_class = CLS_R;
            OPCODE_WIDTH'(OP_I):      o_class = CLS_I;
            OPCODE_WIDTH'(OP_LOAD):   o_class = CLS_LOAD;
            OPCODE_WIDTH'(OP_STORE):  o_class = CLS_STORE;
            OPCODE_WIDTH'(OP_BRANCH): o_class = CLS_BRANCH;
            OPCODE_WIDTH'(OP_JAL):    o_class = CLS_JAL;
            default:                  o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/exec/mem/wb sequencing,
// shared memory port handshake and retired-instruction counter.
// Optional illegal-opcode trap state is enabled by defining MC_SEQUENCER_ILLEGAL_TRAP_EN.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int OPCODE_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    branch_taken,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    adr_src,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    reg_write,
    output logic                    result_src,
    output logic                    alu_src,
    output logic [2:0]              state_o,
    output logic                    instr_retired,
    output logic [CNT_WIDTH-1:0]    retired_cnt,
    output logic                    trap
);

    state_t               r_state;
    state_t               w_next_state;
    instr_class_t         w_class;
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_retired_cnt;

    mc_opdecode #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_opdecode (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Memory handshake: mem_req is held high for the whole memory state and the
    // access completes on the clock edge where mem_req and mem_ready are both 1.
    // Strobes are forced low while rst is high so a reset abandons any access.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        result_src   = 1'b0;
        alu_src      = 1'b0;
        trap         = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = ST_DECODE;
                    end
                end
                ST_DECODE: w_next_state = ST_EXEC;
                ST_EXEC: begin
                    w_next_state = ST_FETCH;
                    case (w_class)
                        CLS_R: begin
                            reg_write = 1'b1;
                            w_retire  = 1'b1;
                        end
                        CLS_I: begin
                            alu_src   = 1'b1;
                            reg_write = 1'b1;
                            w_retire  = 1'b1;
                        end
                        CLS_LOAD: begin
                            alu_src      = 1'b1;
                            w_next_state = ST_MEM_RD;
                        end
                        CLS_STORE: begin
                            alu_src      = 1'b1;
                            w_next_state = ST_MEM_WR;
                        end
                        CLS_BRANCH: begin
                            pc_write = branch_taken;
                            pc_src   = 1'b1;
                            w_retire = 1'b1;
                        end
                        CLS_JAL: begin
                            reg_write = 1'b1;
                            pc_write  = 1'b1;
                            pc_src    = 1'b1;
                            w_retire  = 1'b1;
                        end
                        default: begin
`ifdef MC_SEQUENCER_ILLEGAL_TRAP_EN
                            w_next_state = ST_TRAP;
`else
                            w_retire = 1'b1;
`endif
                        end
                    endcase
                end
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        w_next_state = ST_WB;
                    end
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
                ST_WB: begin
                    reg_write    = 1'b1;
                    result_src   = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end
`ifdef MC_SEQUENCER_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    trap         = 1'b1;
                    w_next_state = ST_TRAP;
                end
`endif
                default: w_next_state = ST_FETCH;
            endcase
        end
    end

    assign state_o       = r_state;
    assign instr_retired = w_retire;
    assign retired_cnt   = r_retired_cnt;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer (CNT_WIDTH=4): per-cycle expected output
// vectors are queued as stimulus is driven and compared by a scoreboard monitor.
module tb_mc_sequencer;

    localparam logic [6:0] T_OP_R      = 7'b0110011;
    localparam logic [6:0] T_OP_I      = 7'b0010011;
    localparam logic [6:0] T_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] T_OP_STORE  = 7'b0100011;
    localparam logic [6:0] T_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] T_OP_JAL    = 7'b1101111;
    localparam logic [6:0] T_OP_BAD    = 7'b1111111;

    // flag vector order: req we adr irw pcw pcs rw res alu ret trap
    localparam logic [10:0] F_REQ = 11'd1 << 10;
    localparam logic [10:0] F_WE  = 11'd1 << 9;
    localparam logic [10:0] F_ADR = 11'd1 << 8;
    localparam logic [10:0] F_IRW = 11'd1 << 7;
    localparam logic [10:0] F_PCW = 11'd1 << 6;
    localparam logic [10:0] F_PCS = 11'd1 << 5;
    localparam logic [10:0] F_RW  = 11'd1 << 4;
    localparam logic [10:0] F_RES = 11'd1 << 3;
    localparam logic [10:0] F_ALU = 11'd1 << 2;
    localparam logic [10:0] F_RET = 11'd1 << 1;
    localparam logic [10:0] F_TRP = 11'd1;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src;
    logic       reg_write, result_src, alu_src, instr_retired, trap;
    logic [2:0] state_o;
    logic [3:0] retired_cnt;

    logic [17:0] exp_q[$];
    logic [3:0]  exp_cnt;
    int          vectors;
    int          miscompares;
    int          cyc;

    mc_sequencer #(.CNT_WIDTH(4), .OPCODE_WIDTH(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src       (alu_src),
        .state_o       (state_o),
        .instr_retired (instr_retired),
        .retired_cnt   (retired_cnt),
        .trap          (trap)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard monitor: one expected vector per driven cycle
    always @(negedge clk) begin
        logic [17:0] exp_v;
        logic [17:0] obs_v;
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = {state_o, mem_req, mem_we, adr_src, ir_write, pc_write, pc_src,
                     reg_write, result_src, alu_src, instr_retired, trap, retired_cnt};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_vec @%0d: got state=%0d flags=%b cnt=%0d, expected state=%0d flags=%b cnt=%0d",
                         cyc, obs_v[17:15], obs_v[14:4], obs_v[3:0],
                         exp_v[17:15], exp_v[14:4], exp_v[3:0]);
            end
        end
    end

    // driver: applies one cycle of inputs and queues the expected outputs
    task automatic drive(input logic r, input logic [6:0] opc, input logic bt, input logic mr,
                         input logic [2:0] st, input logic [10:0] fl, input bit chk);
        @(negedge clk);
        rst          = r;
        opcode       = opc;
        branch_taken = bt;
        mem_ready    = mr;
        if (chk) exp_q.push_back({st, fl, exp_cnt});
        if (r) exp_cnt = 4'd0;
        else if (fl[1]) exp_cnt = exp_cnt + 4'd1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // one instruction from FETCH back to FETCH, with optional fetch and memory stalls
    task automatic run_instr(input logic [6:0] opc, input logic bt, input int fs, input int ms);
        repeat (fs) drive(1'b0, opc, bt, 1'b0, 3'd0, F_REQ, 1'b1);
        drive(1'b0, opc, bt, 1'b1, 3'd0, F_REQ | F_IRW | F_PCW, 1'b1);
        drive(1'b0, opc, bt, rnd_bit(), 3'd1, 11'd0, 1'b1);
        case (opc)
            T_OP_R: drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_RW | F_RET, 1'b1);
            T_OP_I: drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_ALU | F_RW | F_RET, 1'b1);
            T_OP_LOAD: begin
                drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_ALU, 1'b1);
                repeat (ms) drive(1'b0, opc, bt, 1'b0, 3'd3, F_REQ | F_ADR, 1'b1);
                drive(1'b0, opc, bt, 1'b1, 3'd3, F_REQ | F_ADR, 1'b1);
                drive(1'b0, opc, bt, rnd_bit(), 3'd5, F_RW | F_RES | F_RET, 1'b1);
            end
            T_OP_STORE: begin
                drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_ALU, 1'b1);
                repeat (ms) drive(1'b0, opc, bt, 1'b0, 3'd4, F_REQ | F_WE | F_ADR, 1'b1);
                drive(1'b0, opc, bt, 1'b1, 3'd4, F_REQ | F_WE | F_ADR | F_RET, 1'b1);
            end
            T_OP_BRANCH: drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_PCS | F_RET | (bt ? F_PCW : 11'd0), 1'b1);
            T_OP_JAL:    drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_RW | F_PCW | F_PCS | F_RET, 1'b1);
            default: begin
`ifdef MC_SEQUENCER_ILLEGAL_TRAP_EN
                drive(1'b0, opc, bt, rnd_bit(), 3'd2, 11'd0, 1'b1);
`else
                drive(1'b0, opc, bt, rnd_bit(), 3'd2, F_RET, 1'b1);
`endif
            end
        endcase
    endtask

    task automatic test_reset();
        drive(1'b1, T_OP_R, 1'b0, 1'b1, 3'd0, 11'd0, 1'b0);
        drive(1'b1, T_OP_R, 1'b0, 1'b1, 3'd0, 11'd0, 1'b1);
        #3;
        vectors++;
        if (state_o !== 3'd0 || retired_cnt !== 4'd0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: state=%0d cnt=%0d mem_req=%b, expected 0/0/0", state_o, retired_cnt, mem_req);
        end
        drive(1'b0, T_OP_R, 1'b0, 1'b0, 3'd0, F_REQ, 1'b1);
        #3;
        vectors++;
        if (mem_req !== 1'b1 || adr_src !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: mem_req=%b adr_src=%b, expected 1/0", mem_req, adr_src);
        end
    endtask

    task automatic check_cnt(input string name, input logic [3:0] want);
        @(posedge clk);
        #1;
        vectors++;
        if (retired_cnt !== want) begin
            miscompares++;
            $display("FAIL %s: retired_cnt=%0d expected %0d", name, retired_cnt, want);
        end
    endtask

    task automatic test_add();
        run_instr(T_OP_R, 1'b0, 0, 0);
        check_cnt("add_retire", 4'd1);
    endtask

    task automatic test_load_stall();
        logic [3:0] c0 = exp_cnt;
        run_instr(T_OP_LOAD, 1'b0, 0, 3);
        check_cnt("load_retire", c0 + 4'd1);
    endtask

    task automatic test_branch();
        logic [3:0] c0 = exp_cnt;
        run_instr(T_OP_BRANCH, 1'b0, 0, 0);
        run_instr(T_OP_BRANCH, 1'b1, 0, 0);
        check_cnt("branch_retire", c0 + 4'd2);
    endtask

    task automatic test_store_jal_itype();
        logic [3:0] c0 = exp_cnt;
        run_instr(T_OP_STORE, 1'b0, 0, $urandom_range(1, 3));
        run_instr(T_OP_JAL, 1'b0, 0, 0);
        run_instr(T_OP_I, 1'b0, 2, 0);
        check_cnt("store_jal_i_retire", c0 + 4'd3);
    endtask

    task automatic test_illegal();
        logic [3:0] c0 = exp_cnt;
        run_instr(T_OP_BAD, 1'b0, 0, 0);
`ifdef MC_SEQUENCER_ILLEGAL_TRAP_EN
        repeat (10) drive(1'b0, T_OP_BAD, rnd_bit(), rnd_bit(), 3'd6, F_TRP, 1'b1);
        drive(1'b1, T_OP_R, 1'b0, 1'b1, 3'd6, 11'd0, 1'b1);
        drive(1'b0, T_OP_R, 1'b0, 1'b0, 3'd0, F_REQ, 1'b1);
        #3;
        vectors++;
        if (retired_cnt !== 4'd0 || state_o !== 3'd0) begin
            miscompares++;
            $display("FAIL trap_reset: cnt=%0d state=%0d expected 0/0 (prior cnt %0d)", retired_cnt, state_o, c0);
        end
`else
        check_cnt("illegal_nop", c0 + 4'd1);
`endif
    endtask

    task automatic test_wrap();
        logic [3:0] c0 = exp_cnt;
        for (int i = 0; i < 16; i++) begin
            run_instr((i % 2 == 0) ? T_OP_R : T_OP_I, 1'b0, $urandom_range(0, 1), 0);
        end
        check_cnt("wrap16", c0);
    endtask

    task automatic test_reset_mid_store();
        drive(1'b0, T_OP_STORE, 1'b0, 1'b1, 3'd0, F_REQ | F_IRW | F_PCW, 1'b1);
        drive(1'b0, T_OP_STORE, 1'b0, 1'b1, 3'd1, 11'd0, 1'b1);
        drive(1'b0, T_OP_STORE, 1'b0, 1'b1, 3'd2, F_ALU, 1'b1);
        drive(1'b0, T_OP_STORE, 1'b0, 1'b0, 3'd4, F_REQ | F_WE | F_ADR, 1'b1);
        drive(1'b0, T_OP_STORE, 1'b0, 1'b0, 3'd4, F_REQ | F_WE | F_ADR, 1'b1);
        drive(1'b1, T_OP_STORE, 1'b0, 1'b1, 3'd4, 11'd0, 1'b1);
        #3;
        vectors++;
        if (mem_req !== 1'b0 || instr_retired !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_store: mem_req=%b retired=%b expected 0/0", mem_req, instr_retired);
        end
        drive(1'b0, T_OP_R, 1'b0, 1'b0, 3'd0, F_REQ, 1'b1);
        #3;
        vectors++;
        if (retired_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_store_cnt: retired_cnt=%0d expected 0", retired_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[6];
        logic [3:0] c0 = exp_cnt;
        ops = '{T_OP_R, T_OP_I, T_OP_LOAD, T_OP_STORE, T_OP_BRANCH, T_OP_JAL};
        for (int i = 0; i < 10; i++) begin
            run_instr(ops[$urandom_range(0, 5)], rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        check_cnt("back_to_back", c0 + 4'd10);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        exp_cnt      = 4'd0;
        rst          = 1'b1;
        opcode       = T_OP_R;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        test_reset();
        test_add();
        test_load_stall();
        test_branch();
        test_store_jal_itype();
        test_illegal();
        test_wrap();
        test_reset_mid_store();
        test_back_to_back();
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control FSM for the team's RV32I core. Replaces the single-cycle control path so that one shared instruction/data memory port, the ALU and the register file are reused across cycles.
- Sequences fetch, decode, execute, memory and writeback for each instruction, and owns the memory request handshake.
- Sits between the instruction register / datapath and the shared memory. Also keeps a retired-instruction counter.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.
- OPCODE_WIDTH, 7, width of the opcode field, instr[6:0].

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- opcode  in  OPCODE_WIDTH  instr[6:0] from the instruction register. Valid from DECODE onward.
- branch_taken  in  1  Branch condition from the datapath (EQ-derived). Valid in EXEC.
- mem_ready  in  1  Memory completes the current access this cycle.
- mem_req  out  1  Memory access request.
- mem_we  out  1  Write enable, qualified by mem_req.
- adr_src  out  1  Memory address select: 0 = pc, 1 = ALU result.
- ir_write  out  1  Load the instruction register.
- pc_write  out  1  Update pc.
- pc_src  out  1  Next pc select: 0 = pc+4, 1 = pc+ImmOp.
- reg_write  out  1  Register file write enable (WE3).
- result_src  out  1  Writeback select: 0 = ALU or link value, 1 = memory read data.
- alu_src  out  1  ALU operand B select: 0 = register, 1 = ImmOp.
- state_o  out  3  Current state encoding, for debug.
- instr_retired  out  1  One-cycle pulse when an instruction completes.
- retired_cnt  out  CNT_WIDTH  Count of retired instructions.
- trap  out  1  Illegal-opcode trap. Present only under the macro; tied to 0 otherwise.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, TRAP=6.
- Outputs are decoded combinationally from the state, plus mem_ready / branch_taken where noted. Default for every output is 0.
- Reset: state=FETCH, retired_cnt=0. All strobes are 0 during the reset cycle. Reset mid-access abandons the access, and mem_req drops in the cycle rst is high.
- FETCH:
  - mem_req=1, adr_src=0.
  - Wait while mem_ready=0; mem_req stays high and no other strobe fires.
  - On mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
- DECODE: no strobes. Next state EXEC. The opcode is classified here:
  - 0110011 R-type
  - 0010011 I-type ALU
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - anything else: illegal
- EXEC actions by class:
  - R-type: alu_src=0, reg_write=1, retire, go to FETCH.
  - I-type ALU: alu_src=1, reg_write=1, retire, go to FETCH.
  - LOAD: alu_src=1 (address computed), go to MEM_RD.
  - STORE: alu_src=1, go to MEM_WR.
  - BRANCH: pc_write=branch_taken, pc_src=1, retire, go to FETCH.
  - JAL: reg_write=1, result_src=0, pc_write=1, pc_src=1, retire, go to FETCH.
  - Illegal: retire as a NOP, go to FETCH (see Optional Feature).
- MEM_RD: mem_req=1, adr_src=1, mem_we=0. Hold until mem_ready, then go to WB.
- MEM_WR: mem_req=1, adr_src=1, mem_we=1. Hold until mem_ready, then retire and go to FETCH.
- WB: reg_write=1, result_src=1, retire, go to FETCH.
- Retire: instr_retired=1 for exactly one cycle, and retired_cnt increments at the same clock edge. The counter wraps from all-ones to 0.
- Minimum latency with mem_ready tied high:
  - ALU, BRANCH, JAL: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle mem_ready is low inside a memory state adds one cycle. mem_ready is ignored in non-memory states.
- mem_req never deasserts before mem_ready within a memory state. It never asserts in DECODE, EXEC or WB.
- Unused state encoding 7 returns to FETCH on the next edge.

Optional Feature:
- Macro: MC_SEQUENCER_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal opcode in EXEC goes to TRAP and does not retire.
  - TRAP: trap=1, all strobes 0, mem_req=0. Stays in TRAP until rst.
- Undefined:
  - TRAP is unreachable; illegal opcode retires as a NOP.
  - trap is tied to 0.

Decomposition:
- Package mc_pkg holds:
  - the state_t enum (3-bit, encodings above);
  - opcode localparams OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL;
  - an instr_class_t enum.
- Sub-module mc_opdecode: combinational opcode to instr_class_t. It is the only place opcodes are compared.
- The FSM, output decode and counter stay in mc_sequencer.

Test Plan:
- Reset: hold rst 2 cycles with mem_ready=1. Require state_o=0, retired_cnt=0, all strobes 0. After release, mem_req=1 and adr_src=0 on the first cycle.
- ADD (opcode 0110011), mem_ready=1: states 0→1→2→0. ir_write and pc_write fire in cycle 0. reg_write=1 only in cycle 2. instr_retired pulses once; retired_cnt=1.
- LOAD with mem_ready low for 3 cycles in MEM_RD: 8 total cycles. mem_req stays high throughout MEM_RD, then WB with reg_write=1 and result_src=1. retired_cnt increments by 1.
- BRANCH, branch_taken=0 then 1: pc_write=0 in EXEC for the first, pc_write=1 with pc_src=1 for the second. Both retire.
- Opcode 1111111: without the macro, 3 cycles and retired_cnt increments. With the macro, state_o=6, trap=1, no retire, held 10 cycles. Then rst returns to FETCH with retired_cnt=0.
- CNT_WIDTH=4: retire 16 ALU instructions; retired_cnt wraps 15→0. Assert rst mid-MEM_WR: mem_req drops in the reset cycle and no retire occurs.
